wm8731_i2c_slave: RTL
=====================

# wm8731_i2c_slave

Synthesizable responder for the codec's 2-wire control bus: a functional stand-in for the WM8731 control interface at the far end of the I2C link driven by the Avalon codec controller. It decodes I2C write transfers addressed to the codec, ACKs them, and stores the 16-bit control words (7-bit register address plus 9-bit data) in a shadow register file. The register file is readable by the bench or on-chip logic, and each accepted write emits a one-cycle strobe. It sits on the `i2c_sclk`/`i2c_sdat` pair in place of the behavioural I2C model.

## Interface
- `DEV_ADDR`, 7'h1A — 7-bit slave address (WM8731 with CSB low).
- `clk`  in  1  system clock, 50 MHz; oversamples the I2C lines.
- `reset`  in  1  synchronous, active-high reset.
- `i2c_sclk`  in  1  I2C clock from the master; never driven by this block.
- `i2c_sdat`  inout  1  open-drain data line; driven only to 0 (ACK), otherwise `1'bz`.
- `rd_addr`  in  7  register file read address.
- `rd_data`  out  9  combinational read of `rd_addr`; returns 0 for unmapped addresses.
- `reg_wr`  out  1  one-cycle strobe when a register is written.
- `reg_addr`  out  7  address of the last accepted write; held until the next write.
- `reg_data`  out  9  data of the last accepted write; held until the next write.
- `busy`  out  1  high from START until STOP or abort.

## Operation
- **Line sampling.** `i2c_sclk` and `i2c_sdat` each pass through a 2-flop synchronizer plus one history flop. Edges are detected on the synchronized values.
- **START.** SDA falls while SCL is high. Valid in any state, so a repeated START restarts at ADDR and discards any partial word.
- **STOP.** SDA rises while SCL is high. Goes to IDLE from any state; a partial word is discarded and never committed.
- **Bit sampling.** Data bits are taken on the SCL rising edge, MSB first.
- **FSM states:** IDLE, ADDR, ACK_A, HI, ACK_H, LO, ACK_L, IGNORE.
  - IDLE → ADDR on START.
  - ADDR: 8 bits. On the SCL falling edge after bit 8:
    - if addr[7:1]==DEV_ADDR and R/W==0 → ACK_A;
    - otherwise → IGNORE (NACK; the codec is write-only).
  - ACK_A: drive SDA low from that SCL fall until the next SCL fall, then → HI.
  - HI: capture reg_addr[6:0] and data[8]; at the 8th fall → ACK_H.
  - ACK_H: ACK as above, then → LO.
  - LO: capture data[7:0]; at the 8th fall → ACK_L and commit.
  - ACK_L: ACK, then → IGNORE.
  - IGNORE: SDA released; any further bytes are NACKed; wait for START or STOP.
- **Commit.**
  - Mapped addresses 0x00–0x09: write the register and pulse `reg_wr`.
  - Address 0x0F: if data==0, restore all defaults and pulse `reg_wr`; otherwise ACK with no effect and no strobe.
  - Addresses 0x0A–0x0E: ACKed, nothing stored, no strobe.
- **Defaults** (also applied by `reset`):
  - R0 = 0x097, R1 = 0x097, R2 = 0x079, R3 = 0x079, R4 = 0x00A;
  - R5 = 0x008, R6 = 0x09F, R7 = 0x00A, R8 = 0x000, R9 = 0x000.
- **Bit counter.** 3 bits, cleared on START and on entry to each byte state.

## Timing
- **Reset values:** `i2c_sdat` = z, `reg_wr` = 0, `reg_addr` = 0, `reg_data` = 0, `busy` = 0, FSM = IDLE, registers = defaults.
- **Synchronizer latency.** Pin change to detected edge takes 3 clk. This applies equally to ACK drive onset and release after SCL falls.
- **Commit latency.** `reg_wr` asserts 3 clk after the SCL fall that ends LO bit 8. It is high for exactly 1 clk, and `reg_addr`/`reg_data` are valid in that same cycle.
- **Read port.** `rd_data` reflects a write on the clk following `reg_wr`.
- **Simultaneous edges.** If SCL and SDA edges are detected in the same clk, the SCL edge is processed first; START/STOP is recognized only with SCL stable high.
- **Reset mid-transfer.** SDA is released immediately and the FSM goes to IDLE. The next transaction needs a fresh START.
- **Bus-speed limit.** Minimum SCL high/low time is 8 clk (≤3.1 MHz SCL at 50 MHz); no clock stretching.

## Test plan
- **Basic write.** Reset, then START, 0x34, 0x1E 0x00 (R15 data 0), STOP → three ACKs; one `reg_wr` with `reg_addr`=0x0F; all registers at defaults.
- **R4 write.** START, 0x34, 0x08, 0x12, STOP → three ACKs; `reg_wr` with `reg_addr`=0x04, `reg_data`=0x012; `rd_addr`=4 reads 0x012.
- **Wrong address.** Send 0x36 → NACK at bit 9 and no `reg_wr`. Send 0x35 (read) → NACK. SDA stays z throughout.
- **Abort mid-word.** 0x34, 0x0E, then STOP after 4 bits of the low byte → no `reg_wr`, R7 unchanged at 0x00A, `busy` falls.
- **Repeated START.** Repeated START after the high byte, then a full R9 write with data 0x001 → only R9 updated to 0x001.
- **Extra byte and reset.** A third data byte after ACK_L is NACKed. Assert `reset` during ACK_H → SDA released within 1 clk; registers back to defaults.

Source files
------------

// File: rtl/wm8731_i2c_slave_if.sv
// Register-file side of the WM8731 control-bus responder: read port,
// write strobe with the committed word, and the transfer-busy flag.
interface wm8731_i2c_slave_if;
    logic [6:0] rd_addr;
    logic [8:0] rd_data;
    logic       reg_wr;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       busy;

    // The reader of the shadow registers (bench or on-chip logic).
    modport master (output rd_addr, input rd_data, reg_wr, reg_addr, reg_data, busy);
    // The responder itself.
    modport slave  (input rd_addr, output rd_data, reg_wr, reg_addr, reg_data, busy);
endinterface

// File: rtl/wm8731_i2c_slave.sv
// WM8731 control-interface stand-in: decodes I2C writes to DEV_ADDR, ACKs
// each byte and stores the 7-bit address / 9-bit data words in a shadow
// register file that mirrors the codec's power-on defaults.
module wm8731_i2c_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i2c_sclk,
    inout  wire               i2c_sdat,
    wm8731_i2c_slave_if.slave regs_if
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_HI, S_ACK_H, S_LO, S_ACK_L, S_IGNORE
    } state_t;

    state_t     state, state_nx;
    logic       scl_p0, scl_p1, scl_p2;
    logic       sda_p0, sda_p1, sda_p2;
    logic       scl_rise, scl_fall, scl_stable_hi, start_det, stop_det;
    logic       byte_state, commit, sda_oe, busy_c;
    logic [2:0] bit_cnt;
    logic       got8;
    logic [7:0] shreg;
    logic [7:0] hi_q;
    logic [6:0] cm_addr;
    logic [8:0] cm_data;
    logic [8:0] regs [0:9];
    logic       wr_q;
    logic [6:0] addr_q;
    logic [8:0] data_q;

    // Codec power-on value of each mapped register.
    function automatic logic [8:0] dflt(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1: dflt = 9'h097;
            4'd2, 4'd3: dflt = 9'h079;
            4'd4, 4'd7: dflt = 9'h00A;
            4'd5:       dflt = 9'h008;
            4'd6:       dflt = 9'h09F;
            default:    dflt = 9'h000;
        endcase
    endfunction

    // Two synchronizer flops plus one history flop per line; idle bus is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
            sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= i2c_sclk; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
            sda_p0 <= i2c_sdat; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
        end
    end

    // START/STOP only count while SCL is stable high, so an SCL edge in the
    // same cycle always wins.
    assign scl_rise      = scl_p1 & ~scl_p2;
    assign scl_fall      = ~scl_p1 & scl_p2;
    assign scl_stable_hi = scl_p1 & scl_p2;
    assign start_det     = scl_stable_hi & ~sda_p1 & sda_p2;
    assign stop_det      = scl_stable_hi & sda_p1 & ~sda_p2;
    assign byte_state    = (state == S_ADDR) || (state == S_HI) || (state == S_LO);
    assign commit        = (state == S_LO) && (state_nx == S_ACK_L);
    assign cm_addr       = hi_q[7:1];
    assign cm_data       = {hi_q[0], shreg};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // FSM next state: START/STOP override, otherwise advance on SCL falls.
    always_comb begin
        state_nx = state;
        if (start_det) begin
            state_nx = S_ADDR;
        end else if (stop_det) begin
            state_nx = S_IDLE;
        end else if (scl_fall) begin
            case (state)
                S_ADDR:  if (got8) state_nx = (shreg[7:1] == DEV_ADDR && !shreg[0]) ? S_ACK_A : S_IGNORE;
                S_ACK_A: state_nx = S_HI;
                S_HI:    if (got8) state_nx = S_ACK_H;
                S_ACK_H: state_nx = S_LO;
                S_LO:    if (got8) state_nx = S_ACK_L;
                S_ACK_L: state_nx = S_IGNORE;
                default: state_nx = state;
            endcase
        end
    end

    // FSM outputs: pull SDA low only in the ACK slots.
    always_comb begin
        sda_oe = 1'b0;
        busy_c = (state != S_IDLE);
        case (state)
            S_ACK_A, S_ACK_H, S_ACK_L: sda_oe = 1'b1;
            default:                   sda_oe = 1'b0;
        endcase
    end

    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

    // Bit counter; got8 marks a complete byte since the counter wraps to 0.
    always_ff @(posedge clk) begin
        if (reset || start_det || (state_nx != state)) begin
            bit_cnt <= 3'd0;
            got8    <= 1'b0;
        end else if (scl_rise && byte_state) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) got8 <= 1'b1;
        end
    end

    // Byte shifter (MSB first on SCL rise) and latch of the high byte.
    always_ff @(posedge clk) begin
        if (scl_rise && byte_state) shreg <= {shreg[6:0], sda_p1};
        if ((state == S_HI) && (state_nx == S_ACK_H)) hi_q <= shreg;
    end

    // Register file commit: mapped writes, R15 restore-defaults, strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 10; i++) regs[i] <= dflt(4'(i));
            wr_q   <= 1'b0;
            addr_q <= 7'd0;
            data_q <= 9'd0;
        end else begin
            wr_q <= 1'b0;
            if (commit) begin
                if (cm_addr <= 7'd9) begin
                    regs[cm_addr[3:0]] <= cm_data;
                    wr_q   <= 1'b1;
                    addr_q <= cm_addr;
                    data_q <= cm_data;
                end else if ((cm_addr == 7'h0F) && (cm_data == 9'd0)) begin
                    for (int i = 0; i < 10; i++) regs[i] <= dflt(4'(i));
                    wr_q   <= 1'b1;
                    addr_q <= cm_addr;
                    data_q <= cm_data;
                end
            end
        end
    end

    assign regs_if.rd_data  = (regs_if.rd_addr <= 7'd9) ? regs[regs_if.rd_addr[3:0]] : 9'd0;
    assign regs_if.reg_wr   = wr_q;
    assign regs_if.reg_addr = addr_q;
    assign regs_if.reg_data = data_q;
    assign regs_if.busy     = busy_c;
endmodule
